serial_addsub_unit: RTL and testbench
=====================================

# serial_addsub_unit

Parametrised, multi-cycle signed/unsigned adder-subtractor. Processes a WIDTH-bit operation DIGIT bits per clock, least-significant digit first. Reports carry, signed overflow and zero flags alongside the result. Successor to the 4-bit combinational adder/subtractor: it keeps that block's operand, carry and sub_select semantics, and adds width/throughput scaling, a start/busy/done handshake, and status flags for the ALU datapath.

## Interface
- WIDTH, 8: operand and result width; ≥2.
- DIGIT, 1: bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH; must divide WIDTH; N = WIDTH/DIGIT.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  request; sampled only when the block accepts (IDLE or DONE).
- in1  in  WIDTH  operand A; sampled with start.
- in2  in  WIDTH  operand B; sampled with start.
- ci  in  1  carry-in for add, borrow-in for subtract; sampled with start.
- sub_select  in  1  0 = add, 1 = subtract; sampled with start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; the result is valid.
- out  out  WIDTH  result; held until the next completion.
- co  out  1  raw adder carry-out. For subtract, 1 means no borrow.
- ovf  out  1  two's-complement overflow.
- zero  out  1  out == 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1: latch the operands, the effective B and the effective carry-in; clear the digit counter; go to RUN.
- Add: out = in1 + in2 + ci, computed as in1 + in2 + ci.
- Subtract: out = in1 − in2 − ci, computed as in1 + ~in2 + ~ci.
- RUN: each cycle adds one DIGIT slice of A and effective B with the running carry. The sum slice shifts into the result shift register and the counter increments.
- After slice N−1, go to DONE. In the same edge, load out, co, ovf and zero from the completed result.
- ovf = carry into MSB XOR carry out of MSB, both taken from the final slice.
- zero = (out == 0), computed from the completed result.
- DONE lasts one cycle, with done=1. If start=1 in DONE, a new operation is accepted exactly as from IDLE, so operations run back-to-back. Otherwise the state returns to IDLE.
- start while in RUN: ignored, with no queuing.
- Operand changes during RUN: no effect, because operands are latched at acceptance.
- Flag outputs change only at completion. They are not updated during RUN.

## Timing
- Reset (rst_n=0 at an edge):
  - state returns to IDLE;
  - out, co, ovf, zero, busy and done all go to 0;
  - internal registers clear.
- Reset has priority over start.
- Reset during RUN aborts the operation. done never pulses, and the prior result is lost.
- Let edge E0 be the edge that accepts start.
  - busy=1 from E0 to E_N.
  - E1 … E_N each process one slice.
  - At E_N the state enters DONE: done=1, busy=0, and the result is valid.
- Latency is N cycles from the accepting edge to done.
- Initiation interval is N+1 cycles when start is held high.
- DIGIT=WIDTH: N=1. Done appears one cycle after acceptance.
- Digit counter width is clog2(N), minimum 1. It wraps to 0 on acceptance.

## Structure
- Package serial_addsub_pkg contains:
  - state enum (IDLE, RUN, DONE);
  - op encoding constants (OP_ADD=0, OP_SUB=1);
  - a function computing N and the counter width.
- Sub-module serial_addsub_digit:
  - combinational DIGIT-bit ripple slice;
  - inputs: a, b, cin;
  - outputs: sum, cout, and c_msb_in (carry into the slice MSB, used for ovf).
- Top level holds the FSM, counter, operand shift registers, result shift register and flag registers.

## Test plan
1. Add, WIDTH=8, DIGIT=1: 8'hFF + 8'hFE, ci=1.
   - out=8'hFE, co=1, ovf=0, zero=0.
   - done exactly 8 cycles after acceptance; busy high for those 8 cycles.
2. Subtract, WIDTH=8, DIGIT=1:
   - 2−1, ci=0 → out=8'h01, co=1.
   - 2−3, ci=1 → out=8'hFE (−2), co=0, ovf=0.
3. Overflow, WIDTH=8, DIGIT=1:
   - 8'h7F + 8'h01, ci=0 → 8'h80, ovf=1, co=0.
   - 8'h80 − 8'h01, ci=0 → 8'h7F, ovf=1, co=1.
   - 8'h05 − 8'h05, ci=0 → 8'h00, zero=1, co=1.
4. WIDTH=16, DIGIT=4: 16'h1234 + 16'h0FCC, ci=0 → 16'h2200, co=0.
   - done 4 cycles after acceptance.
   - start pulses during RUN are ignored.
   - Holding start high gives back-to-back completions every 5 cycles.
5. DIGIT=WIDTH=8: 8'h10 + 8'h20, ci=0 → 8'h30, done 1 cycle after acceptance.
6. Reset mid-operation: assert rst_n=0 during the 3rd RUN cycle.
   - Next edge: all outputs 0, state IDLE, no done pulse.
   - A following start completes normally with the correct result.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
package serial_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Number of slices needed to cover the operand.
   function automatic int calc_n(input int width, input int digit);
      return width / digit;
   endfunction

   // Digit counter width: clog2(N), never narrower than one bit.
   function automatic int calc_cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serial_addsub_digit.sv
// Combinational DIGIT-bit ripple-carry slice; also exposes the carry into its MSB
// so the top level can derive signed overflow from the final slice.
module serial_addsub_digit #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout,
   output logic             c_msb_in
);

   always_comb begin
      // NOTE: blocking assignments are correct here: c is a combinational
      // temporary that must ripple through the loop within one evaluation.
      logic c;
      c        = cin;
      sum      = '0;
      c_msb_in = 1'b0;
      for (int i = 0; i < DIGIT; i++) begin
         if (i == DIGIT - 1) c_msb_in = c;
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/serial_addsub_unit.sv
// Digit-serial signed/unsigned adder-subtractor, LS digit first, with a
// start/busy/done handshake and carry, overflow and zero flags.
module serial_addsub_unit
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             ci,
   input  logic             sub_select,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic             co,
   output logic             ovf,
   output logic             zero
);

   localparam int N  = calc_n(WIDTH, DIGIT);
   localparam int CW = calc_cnt_width(N);

   state_t state, next_state;

   logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [DIGIT-1:0] sum;
   logic             cout, c_msb_in;
   logic             last, accept;

   assign last = (cnt == CW'(N - 1));

   serial_addsub_digit #(.DIGIT(DIGIT)) u_digit (
      .a        (a_sr[DIGIT-1:0]),
      .b        (b_sr[DIGIT-1:0]),
      .cin      (carry),
      .sum      (sum),
      .cout     (cout),
      .c_msb_in (c_msb_in)
   );

   // New slice enters at the top; after N shifts the LS digit sits at bit 0.
   assign res_next = (res_sr >> DIGIT) | (WIDTH'(sum) << (WIDTH - DIGIT));

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      busy       = 1'b0;
      done       = 1'b0;
      accept     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               next_state = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last) next_state = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               accept     = 1'b1;
               next_state = RUN;
            end else begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: every datapath register, not just the FSM, is cleared so a
      // reset mid-operation leaves no stale result or flags visible.
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         out    <= '0;
         co     <= 1'b0;
         ovf    <= 1'b0;
         zero   <= 1'b0;
      end else if (accept) begin
         // Subtract is in1 + ~in2 + ~ci, so the inversion happens once here.
         a_sr   <= in1;
         b_sr   <= (sub_select == OP_SUB) ? ~in2 : in2;
         carry  <= (sub_select == OP_SUB) ? ~ci  : ci;
         res_sr <= '0;
         cnt    <= '0;
      end else if (state == RUN) begin
         a_sr   <= a_sr >> DIGIT;
         b_sr   <= b_sr >> DIGIT;
         carry  <= cout;
         res_sr <= res_next;
         cnt    <= cnt + CW'(1);
         if (last) begin
            out  <= res_next;
            co   <= cout;
            ovf  <= cout ^ c_msb_in;
            zero <= (res_next == '0);
         end
      end
   end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Directed bench for serial_addsub_unit across 8/1, 16/4 and 8/8 configurations.
module tb_serial_addsub_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Per-instance stimulus and observation.
   logic       st0, ci0, sb0, bz0, dn0, co0, ov0, zr0;
   logic [7:0] a0, b0, o0;
   logic       st1, ci1, sb1, bz1, dn1, co1, ov1, zr1;
   logic [15:0] a1, b1, o1;
   logic       st2, ci2, sb2, bz2, dn2, co2, ov2, zr2;
   logic [7:0] a2, b2, o2;

   serial_addsub_unit #(.WIDTH(8), .DIGIT(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .start(st0), .in1(a0), .in2(b0), .ci(ci0),
      .sub_select(sb0), .busy(bz0), .done(dn0), .out(o0), .co(co0), .ovf(ov0), .zero(zr0));
   serial_addsub_unit #(.WIDTH(16), .DIGIT(4)) u_d4 (
      .clk(clk), .rst_n(rst_n), .start(st1), .in1(a1), .in2(b1), .ci(ci1),
      .sub_select(sb1), .busy(bz1), .done(dn1), .out(o1), .co(co1), .ovf(ov1), .zero(zr1));
   serial_addsub_unit #(.WIDTH(8), .DIGIT(8)) u_d8 (
      .clk(clk), .rst_n(rst_n), .start(st2), .in1(a2), .in2(b2), .ci(ci2),
      .sub_select(sb2), .busy(bz2), .done(dn2), .out(o2), .co(co2), .ovf(ov2), .zero(zr2));

   // Output mux so one set of tasks can observe any instance.
   int          sel = 0;
   logic [15:0] m_out;
   logic        m_busy, m_done, m_co, m_ovf, m_zero;
   always_comb begin
      m_out = '0; m_busy = 1'b0; m_done = 1'b0; m_co = 1'b0; m_ovf = 1'b0; m_zero = 1'b0;
      case (sel)
         0: begin m_out = {8'h00, o0}; m_busy = bz0; m_done = dn0; m_co = co0; m_ovf = ov0; m_zero = zr0; end
         1: begin m_out = o1;          m_busy = bz1; m_done = dn1; m_co = co1; m_ovf = ov1; m_zero = zr1; end
         default: begin m_out = {8'h00, o2}; m_busy = bz2; m_done = dn2; m_co = co2; m_ovf = ov2; m_zero = zr2; end
      endcase
   end

   task automatic drive(input int s, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic sub, input logic go);
      case (s)
         0: begin a0 = a[7:0]; b0 = b[7:0]; ci0 = c; sb0 = sub; st0 = go; end
         1: begin a1 = a;      b1 = b;      ci1 = c; sb1 = sub; st1 = go; end
         default: begin a2 = a[7:0]; b2 = b[7:0]; ci2 = c; sb2 = sub; st2 = go; end
      endcase
   endtask

   task automatic set_start(input int s, input logic go);
      case (s)
         0: st0 = go;
         1: st1 = go;
         default: st2 = go;
      endcase
   endtask

   task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Waits for done after acceptance, checking busy every cycle; returns latency.
   task automatic wait_done(input string name, output int lat);
      lat = 0;
      while (lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (m_done === 1'b1) break;
         checks++;
         if (m_busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy: got %b expected 1 at cycle %0d", name, m_busy, lat);
         end
      end
      if (m_done !== 1'b1) begin
         checks++; failures++;
         $display("FAIL %s timeout: got no done expected done within 40 cycles", name);
      end
   endtask

   task automatic do_op(input string name, input int s, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic sub, input logic [15:0] e_out,
                        input logic e_co, input logic e_ovf, input logic e_zero, input int e_lat);
      int lat;
      sel = s;
      drive(s, a, b, c, sub, 1'b1);
      @(posedge clk); #1;
      set_start(s, 1'b0);
      if (e_lat > 1) cmp({name, " busy_e0"}, {15'd0, m_busy}, 16'd1);
      wait_done(name, lat);
      cmp({name, " latency"}, lat[15:0], e_lat[15:0]);
      cmp({name, " busy_at_done"}, {15'd0, m_busy}, 16'd0);
      cmp({name, " out"}, m_out, e_out);
      cmp({name, " co"}, {15'd0, m_co}, {15'd0, e_co});
      cmp({name, " ovf"}, {15'd0, m_ovf}, {15'd0, e_ovf});
      cmp({name, " zero"}, {15'd0, m_zero}, {15'd0, e_zero});
      @(posedge clk); #1;
      cmp({name, " done_pulse"}, {15'd0, m_done}, 16'd0);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      cmp("rst d1 out", {8'h00, o0}, 16'h0000);
      cmp("rst d1 flags", {10'd0, bz0, dn0, co0, ov0, zr0, 1'b0}, 16'h0000);
      cmp("rst d4 out", o1, 16'h0000);
      cmp("rst d4 flags", {10'd0, bz1, dn1, co1, ov1, zr1, 1'b0}, 16'h0000);
      cmp("rst d8 flags", {2'd0, o2, bz2, dn2, co2, ov2, zr2, 1'b0}, 16'h0000);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_add;
      do_op("add_ff_fe", 0, 16'h00FF, 16'h00FE, 1'b1, 1'b0, 16'h00FE, 1'b1, 1'b0, 1'b0, 8);
   endtask

   task automatic test_sub;
      do_op("sub_2_1", 0, 16'h0002, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 8);
      do_op("sub_2_3_b", 0, 16'h0002, 16'h0003, 1'b1, 1'b1, 16'h00FE, 1'b0, 1'b0, 1'b0, 8);
   endtask

   task automatic test_overflow;
      do_op("ovf_add", 0, 16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1, 1'b0, 8);
      do_op("ovf_sub", 0, 16'h0080, 16'h0001, 1'b0, 1'b1, 16'h007F, 1'b1, 1'b1, 1'b0, 8);
      do_op("zero_sub", 0, 16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 8);
   endtask

   task automatic test_digit4;
      do_op("d4_add", 1, 16'h1234, 16'h0FCC, 1'b0, 1'b0, 16'h2200, 1'b0, 1'b0, 1'b0, 4);
   endtask

   task automatic test_ignore_start;
      int lat;
      sel = 1;
      drive(1, 16'h1234, 16'h0FCC, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
      drive(1, 16'hAAAA, 16'h1111, 1'b1, 1'b1, 1'b0);
      @(posedge clk); #1;
      set_start(1, 1'b1);           // pulse during RUN with other operands
      @(posedge clk); #1;
      set_start(1, 1'b0);
      lat = 2;
      while (lat < 40 && m_done !== 1'b1) begin
         @(posedge clk); #1;
         lat++;
      end
      cmp("ign latency", lat[15:0], 16'd4);
      cmp("ign out", m_out, 16'h2200);
      // Nothing was queued: no second completion follows.
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (m_done === 1'b1 || m_busy === 1'b1) begin
            checks++; failures++;
            $display("FAIL ign queued: got done=%b busy=%b expected idle", m_done, m_busy);
            break;
         end
      end
      cmp("ign idle", {14'd0, m_busy, m_done}, 16'd0);
   endtask

   task automatic test_back_to_back;
      int cyc;
      int hits;
      int first_c, second_c;
      logic [15:0] second_out;
      logic second_zero, second_co;
      sel = 1;
      drive(1, 16'h1234, 16'h0FCC, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
      // First operation is latched; the second picks up these operands.
      drive(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
      cyc = 0; hits = 0; first_c = 0; second_c = 0;
      second_out = '0; second_zero = 1'b0; second_co = 1'b0;
      while (cyc < 40 && hits < 2) begin
         @(posedge clk); #1;
         cyc++;
         if (m_done === 1'b1) begin
            hits++;
            if (hits == 1) begin
               first_c = cyc;
               cmp("b2b out1", m_out, 16'h2200);
            end else begin
               second_c = cyc;
               second_out = m_out; second_zero = m_zero; second_co = m_co;
            end
         end
      end
      set_start(1, 1'b0);
      cmp("b2b first", first_c[15:0], 16'd4);
      cmp("b2b interval", 16'(second_c - first_c), 16'd5);
      cmp("b2b out2", second_out, 16'h0000);
      cmp("b2b zero2", {15'd0, second_zero}, 16'd1);
      cmp("b2b co2", {15'd0, second_co}, 16'd1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_full_digit;
      do_op("d8_add", 2, 16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b0, 1);
   endtask

   task automatic test_reset_mid;
      sel = 0;
      drive(0, 16'h0033, 16'h0044, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;            // E0
      set_start(0, 1'b0);
      repeat (2) @(posedge clk);     // E1, E2
      #1;
      rst_n = 1'b0;                  // reset lands in the 3rd RUN cycle
      @(posedge clk); #1;
      cmp("rstmid out", {8'h00, o0}, 16'h0000);
      cmp("rstmid flags", {11'd0, bz0, dn0, co0, ov0, zr0}, 16'h0000);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (dn0 === 1'b1) begin
            checks++; failures++;
            $display("FAIL rstmid done: got done=1 expected 0 after abort");
            break;
         end
      end
      cmp("rstmid idle", {14'd0, bz0, dn0}, 16'd0);
      do_op("rstmid_next", 0, 16'h0033, 16'h0044, 1'b1, 1'b0, 16'h0078, 1'b0, 1'b0, 1'b0, 8);
   endtask

   initial begin
      drive(0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      drive(1, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      drive(2, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      test_reset;
      test_add;
      test_sub;
      test_overflow;
      test_digit4;
      test_ignore_start;
      test_back_to_back;
      test_full_digit;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
